// File: rtl/cache_pkg.sv
// Shared L1 cache definitions: bus widths, C1/C2 opcodes, address layout
// and the CPU-port FSM state encoding.
package cache_pkg;

   localparam int TAG_SIZE       = 10;
   localparam int SET_SIZE       = 5;
   localparam int OFFSET_SIZE    = 4;
   localparam int ADDR1_BUS_SIZE = 15;
   localparam int DATA_BUS_SIZE  = 16;
   localparam int CTR1_BUS_SIZE  = 3;
   localparam int CTR2_BUS_SIZE  = 2;

   localparam logic [CTR1_BUS_SIZE-1:0] C1_NOP             = 3'd0;
   localparam logic [CTR1_BUS_SIZE-1:0] C1_READ8           = 3'd1;
   localparam logic [CTR1_BUS_SIZE-1:0] C1_READ16          = 3'd2;
   localparam logic [CTR1_BUS_SIZE-1:0] C1_READ32          = 3'd3;
   localparam logic [CTR1_BUS_SIZE-1:0] C1_INVALIDATE_LINE = 3'd4;
   localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE8          = 3'd5;
   localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE16         = 3'd6;
   localparam logic [CTR1_BUS_SIZE-1:0] C1_WRITE32         = 3'd7;
   localparam logic [CTR1_BUS_SIZE-1:0] C1_RESPONSE        = 3'd7;

   localparam logic [CTR2_BUS_SIZE-1:0] C2_NOP        = 2'd0;
   localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = 2'd1;
   localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = 2'd2;
   localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = 2'd3;

   typedef struct packed {
      logic [TAG_SIZE-1:0]    tag;
      logic [SET_SIZE-1:0]    set;
      logic [OFFSET_SIZE-1:0] offset;
   } cache_addr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR2,
      ST_DATA2,
      ST_CORE,
      ST_TURN,
      ST_RESP1,
      ST_RESP2,
      ST_REL
   } cpu_port_state_t;

   function automatic logic is_write(input logic [CTR1_BUS_SIZE-1:0] cmd);
      return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
   endfunction

   function automatic logic is_read(input logic [CTR1_BUS_SIZE-1:0] cmd);
      return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
   endfunction

endpackage

// File: rtl/cache_cpu_port_tristate.sv
// Generic tristate driver: puts value on an inout bus while oe is high,
// otherwise leaves the bus floating for other agents.
module bus_tristate_drv #(
   parameter int WIDTH = 8
) (
   input  logic             oe,
   input  logic [WIDTH-1:0] value,
   inout  wire  [WIDTH-1:0] bus
);

   assign bus = oe ? value : {WIDTH{1'bz}};

endmodule

// File: rtl/cache_cpu_port.sv
// CPU-side bus slave of the L1 cache: turns the multi-tick C1/A1/D1 protocol
// into one flat request for the core and plays the response back on the bus.
module cache_cpu_port
   import cache_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   inout  wire  [CTR1_BUS_SIZE-1:0]  C1,
   input  logic [ADDR1_BUS_SIZE-1:0] A1,
   inout  wire  [DATA_BUS_SIZE-1:0]  D1,
   output logic                      req_valid,
   output logic [CTR1_BUS_SIZE-1:0]  req_cmd,
   output logic [$bits(cache_addr_t)-1:0] req_addr,
   output logic [31:0]               req_wdata,
   input  logic                      core_done,
   input  logic [31:0]               core_rdata,
   output logic                      busy
);

   cpu_port_state_t            state_q, state_d;
   logic [CTR1_BUS_SIZE-1:0]   cmd_q, cmd_d;
   cache_addr_t                addr_q, addr_d;
   logic [31:0]                wdata_q, wdata_d;
   logic [31:0]                rdata_q, rdata_d;
   logic                       busy_q, busy_d;
   logic                       c1_oe_q, c1_oe_d;
   logic                       d1_oe_q, d1_oe_d;
   logic [DATA_BUS_SIZE-1:0]   d1_out_q, d1_out_d;

   always_comb begin
      state_d  = state_q;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      busy_d   = busy_q;
      c1_oe_d  = 1'b0;
      d1_oe_d  = 1'b0;
      d1_out_d = '0;

      case (state_q)
         ST_IDLE: begin
            // X/Z on C1 makes this comparison non-true, so it falls to NOP.
            if (C1 != C1_NOP) begin
               cmd_d       = C1;
               addr_d.tag  = A1[ADDR1_BUS_SIZE-1:SET_SIZE];
               addr_d.set  = A1[SET_SIZE-1:0];
               wdata_d     = '0;
               busy_d      = 1'b1;
               state_d     = ST_ADDR2;
            end
         end
         ST_ADDR2: begin
            addr_d.offset = A1[OFFSET_SIZE-1:0];
            if (is_write(cmd_q)) begin
               wdata_d[15:0] = (cmd_q == C1_WRITE8) ? {8'h00, D1[7:0]} : D1;
            end
            state_d = (cmd_q == C1_WRITE32) ? ST_DATA2 : ST_CORE;
         end
         ST_DATA2: begin
            wdata_d[31:16] = D1;
            state_d        = ST_CORE;
         end
         ST_CORE: begin
            if (core_done) begin
               rdata_d = core_rdata;
               state_d = ST_TURN;
            end
         end
         ST_TURN:  state_d = ST_RESP1;
         ST_RESP1: state_d = (cmd_q == C1_READ32) ? ST_RESP2 : ST_REL;
         ST_RESP2: state_d = ST_REL;
         ST_REL: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase

      // Driver enables are registered, so they are decoded from the next state.
      if (state_d == ST_RESP1) begin
         c1_oe_d  = 1'b1;
         d1_oe_d  = is_read(cmd_q);
         d1_out_d = (cmd_q == C1_READ8) ? {8'h00, rdata_d[7:0]} : rdata_d[15:0];
      end else if (state_d == ST_RESP2) begin
         c1_oe_d  = 1'b1;
         d1_oe_d  = 1'b1;
         d1_out_d = rdata_d[31:16];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cmd_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         busy_q   <= 1'b0;
         c1_oe_q  <= 1'b0;
         d1_oe_q  <= 1'b0;
         d1_out_q <= '0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
         c1_oe_q  <= c1_oe_d;
         d1_oe_q  <= d1_oe_d;
         d1_out_q <= d1_out_d;
      end
   end

   assign req_valid = (state_q == ST_CORE);
   assign req_cmd   = cmd_q;
   assign req_addr  = addr_q;
   assign req_wdata = wdata_q;
   assign busy      = busy_q;

   bus_tristate_drv #(.WIDTH(CTR1_BUS_SIZE)) u_c1_drv (
      .oe    (c1_oe_q),
      .value (C1_RESPONSE),
      .bus   (C1)
   );

   bus_tristate_drv #(.WIDTH(DATA_BUS_SIZE)) u_d1_drv (
      .oe    (d1_oe_q),
      .value (d1_out_q),
      .bus   (D1)
   );

endmodule

// File: tb/tb_cache_cpu_port.sv
// Directed bench for cache_cpu_port: plays CPU-side bus transactions and a
// core with programmable latency, checking request and response phases.
module tb_cache_cpu_port;
   import cache_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        c1_drv_en = 1'b0;
   logic [2:0]  c1_drv = '0;
   logic        d1_drv_en = 1'b0;
   logic [15:0] d1_drv = '0;
   logic [14:0] A1 = '0;
   wire  [2:0]  C1;
   wire  [15:0] D1;
   logic        req_valid;
   logic [2:0]  req_cmd;
   logic [18:0] req_addr;
   logic [31:0] req_wdata;
   logic        core_done = 1'b0;
   logic [31:0] core_rdata = '0;
   logic        busy;

   int total = 0;
   int bad = 0;

   assign C1 = c1_drv_en ? c1_drv : 3'bzzz;
   assign D1 = d1_drv_en ? d1_drv : 16'hzzzz;

   always #5 clk = ~clk;

   cache_cpu_port dut (
      .clk        (clk),
      .reset      (reset),
      .C1         (C1),
      .A1         (A1),
      .D1         (D1),
      .req_valid  (req_valid),
      .req_cmd    (req_cmd),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .core_done  (core_done),
      .core_rdata (core_rdata),
      .busy       (busy)
   );

   // A released bus reads as Z in a four-state simulator and as 0 in a two-state one.
   function automatic logic c1_free();
      return $isunknown(C1) || (C1 == 3'd0);
   endfunction

   function automatic logic d1_free();
      return $isunknown(D1) || (D1 == 16'd0);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drives the request phase; returns at the negedge of the first CORE cycle.
   task automatic applyStimulus(input logic [2:0] cmd, input logic [14:0] a1_first,
                                input logic [14:0] a1_second, input logic [15:0] d1_lo,
                                input logic [15:0] d1_hi, output logic valid_early);
      @(negedge clk);
      c1_drv_en = 1'b1;
      c1_drv    = cmd;
      A1        = a1_first;
      @(negedge clk);
      c1_drv_en = 1'b0;
      A1        = a1_second;
      d1_drv_en = (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
      d1_drv    = d1_lo;
      @(negedge clk);
      valid_early = req_valid;
      if (cmd == C1_WRITE32) begin
         d1_drv = d1_hi;
         @(negedge clk);
      end
      d1_drv_en = 1'b0;
   endtask

   // Holds the core busy for wait_cycles CORE cycles, then pulses core_done.
   task automatic finish_core(input int wait_cycles, input logic [31:0] rdata, output int valid_cycles);
      valid_cycles = 0;
      for (int i = 0; i < wait_cycles; i++) begin
         if (req_valid) valid_cycles++;
         @(negedge clk);
      end
      if (req_valid) valid_cycles++;
      core_done  = 1'b1;
      core_rdata = rdata;
      @(negedge clk);
      core_done  = 1'b0;
      core_rdata = 32'h5A5A_5A5A;
   endtask

   // Called at the negedge of the TURN cycle; walks TURN, RESP1, [RESP2], REL, IDLE.
   task automatic check_response(input string tag, input logic [2:0] cmd, input logic [31:0] rdata);
      logic is_rd;
      is_rd = (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
      checkOutput({tag, "_turn_c1_free"}, {31'd0, c1_free()}, 32'd1);
      checkOutput({tag, "_turn_d1_free"}, {31'd0, d1_free()}, 32'd1);
      checkOutput({tag, "_turn_req_valid"}, {31'd0, req_valid}, 32'd0);
      @(negedge clk);
      checkOutput({tag, "_resp1_c1"}, {29'd0, C1}, 32'd7);
      if (is_rd)
         checkOutput({tag, "_resp1_d1"}, {16'd0, D1},
                     (cmd == C1_READ8) ? {24'd0, rdata[7:0]} : {16'd0, rdata[15:0]});
      else
         checkOutput({tag, "_resp1_d1_free"}, {31'd0, d1_free()}, 32'd1);
      if (cmd == C1_READ32) begin
         @(negedge clk);
         checkOutput({tag, "_resp2_c1"}, {29'd0, C1}, 32'd7);
         checkOutput({tag, "_resp2_d1"}, {16'd0, D1}, {16'd0, rdata[31:16]});
      end
      @(negedge clk);
      checkOutput({tag, "_rel_c1_free"}, {31'd0, c1_free()}, 32'd1);
      checkOutput({tag, "_rel_d1_free"}, {31'd0, d1_free()}, 32'd1);
      checkOutput({tag, "_rel_busy"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      checkOutput({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic early;
      int   vcnt;

      // Reset state
      #12;
      checkOutput("rst_req_valid", {31'd0, req_valid}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_req_cmd", {29'd0, req_cmd}, 32'd0);
      checkOutput("rst_req_addr", {13'd0, req_addr}, 32'd0);
      checkOutput("rst_req_wdata", req_wdata, 32'd0);
      checkOutput("rst_c1_free", {31'd0, c1_free()}, 32'd1);
      checkOutput("rst_d1_free", {31'd0, d1_free()}, 32'd1);
      @(negedge clk);
      reset = 1'b0;

      // NOP in IDLE: C1 at 0, then floating
      for (int i = 0; i < 10; i++) begin
         c1_drv_en = (i < 5);
         c1_drv    = 3'd0;
         A1        = 15'h7FFF;
         @(negedge clk);
         checkOutput("nop_busy", {31'd0, busy}, 32'd0);
         checkOutput("nop_d1_free", {31'd0, d1_free()}, 32'd1);
         if (i >= 5) checkOutput("nop_c1_free", {31'd0, c1_free()}, 32'd1);
      end
      c1_drv_en = 1'b0;

      // WRITE8: tag 41, set 25, offset 8; only D1[7:0] kept
      applyStimulus(C1_WRITE8, 15'd1337, 15'd8, 16'hA5E4, 16'h0000, early);
      checkOutput("w8_valid_early", {31'd0, early}, 32'd1);
      checkOutput("w8_req_valid", {31'd0, req_valid}, 32'd1);
      checkOutput("w8_busy", {31'd0, busy}, 32'd1);
      checkOutput("w8_req_cmd", {29'd0, req_cmd}, 32'd5);
      checkOutput("w8_req_addr", {13'd0, req_addr}, {13'd0, 10'd41, 5'd25, 4'd8});
      checkOutput("w8_req_wdata", req_wdata, 32'h0000_00E4);
      finish_core(0, 32'hFFFF_FFFF, vcnt);
      check_response("w8", C1_WRITE8, 32'hFFFF_FFFF);

      // WRITE16
      applyStimulus(C1_WRITE16, 15'h7FE0, 15'h0003, 16'hBEEF, 16'h0000, early);
      checkOutput("w16_valid_early", {31'd0, early}, 32'd1);
      checkOutput("w16_req_addr", {13'd0, req_addr}, {13'd0, 10'h3FF, 5'd0, 4'd3});
      checkOutput("w16_req_wdata", req_wdata, 32'h0000_BEEF);
      finish_core(2, 32'h1111_2222, vcnt);
      checkOutput("w16_valid_cycles", vcnt, 32'd3);
      check_response("w16", C1_WRITE16, 32'h1111_2222);

      // WRITE32: request one cycle later than WRITE16
      applyStimulus(C1_WRITE32, 15'h001F, 15'h000F, 16'h1234, 16'hABCD, early);
      checkOutput("w32_valid_early", {31'd0, early}, 32'd0);
      checkOutput("w32_req_valid", {31'd0, req_valid}, 32'd1);
      checkOutput("w32_req_addr", {13'd0, req_addr}, {13'd0, 10'd0, 5'd31, 4'd15});
      checkOutput("w32_req_wdata", req_wdata, 32'hABCD_1234);
      finish_core(0, 32'h7777_7777, vcnt);
      check_response("w32", C1_WRITE32, 32'h7777_7777);

      // READ32
      applyStimulus(C1_READ32, 15'h0421, 15'h0004, 16'h0000, 16'h0000, early);
      checkOutput("r32_req_cmd", {29'd0, req_cmd}, 32'd3);
      checkOutput("r32_req_addr", {13'd0, req_addr}, {13'd0, 10'd33, 5'd1, 4'd4});
      checkOutput("r32_req_wdata", req_wdata, 32'd0);
      finish_core(1, 32'hDEAD_BEEF, vcnt);
      check_response("r32", C1_READ32, 32'hDEAD_BEEF);

      // INVALIDATE_LINE: core_done in the 20th CORE cycle
      applyStimulus(C1_INVALIDATE_LINE, 15'h2AAA, 15'h0000, 16'h0000, 16'h0000, early);
      finish_core(19, 32'hCAFE_F00D, vcnt);
      checkOutput("inv_valid_cycles", vcnt, 32'd20);
      check_response("inv", C1_INVALIDATE_LINE, 32'hCAFE_F00D);

      // Reset mid-CORE during READ16, then a stale core_done
      applyStimulus(C1_READ16, 15'h1234, 15'h0006, 16'h0000, 16'h0000, early);
      checkOutput("r16_req_valid", {31'd0, req_valid}, 32'd1);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("arst_req_valid", {31'd0, req_valid}, 32'd0);
      checkOutput("arst_busy", {31'd0, busy}, 32'd0);
      checkOutput("arst_req_addr", {13'd0, req_addr}, 32'd0);
      checkOutput("arst_req_cmd", {29'd0, req_cmd}, 32'd0);
      checkOutput("arst_c1_free", {31'd0, c1_free()}, 32'd1);
      checkOutput("arst_d1_free", {31'd0, d1_free()}, 32'd1);
      @(negedge clk);
      reset      = 1'b0;
      core_done  = 1'b1;
      core_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      core_done  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("stale_c1_free", {31'd0, c1_free()}, 32'd1);
         checkOutput("stale_busy", {31'd0, busy}, 32'd0);
      end

      // READ8 after reset, zero-wait core
      applyStimulus(C1_READ8, 15'h0001, 15'h0009, 16'h0000, 16'h0000, early);
      checkOutput("r8_req_addr", {13'd0, req_addr}, {13'd0, 10'd0, 5'd1, 4'd9});
      finish_core(0, 32'h1234_56A5, vcnt);
      check_response("r8", C1_READ8, 32'h1234_56A5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
